rvfi_commit_serializer: RTL and testbench

Sits between the out-of-order core's reorder-buffer retire port and the RVFI monitor/spike log printer. Accepts up to two retired-instruction records per cycle, in program order, buffers them in a FIFO, and replays them on the RVFI side one per cycle with a running commit order number. It also asserts a sticky `halt` when the spike halt idiom retires, and flags protocol errors.

---
 rtl/rvfi_commit_serializer_if.sv | 28 ++
 rtl/rvfi_commit_serializer.sv | 80 ++++++++
 tb/tb_rvfi_commit_serializer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/rvfi_commit_serializer_if.sv
// Retire-port and RVFI-side signal bundle for the commit serializer.
// The slave modport is the serializer; the master modport is the core/monitor side.
interface rvfi_commit_serializer_if #(
   parameter int REC_W = 206
);
   logic [1:0]       commit_valid;
   logic [REC_W-1:0] commit_rec0;
   logic [REC_W-1:0] commit_rec1;
   logic             commit_ready;
   logic             rvfi_commit;
   logic [REC_W-1:0] rvfi_rec;
   logic [63:0]      rvfi_order;
   logic             halt;
   logic             overflow_err;
   logic             protocol_err;

   modport master (
      output commit_valid, commit_rec0, commit_rec1,
      input  commit_ready, rvfi_commit, rvfi_rec, rvfi_order,
      input  halt, overflow_err, protocol_err
   );

   modport slave (
      input  commit_valid, commit_rec0, commit_rec1,
      output commit_ready, rvfi_commit, rvfi_rec, rvfi_order,
      output halt, overflow_err, protocol_err
   );
endinterface

// File: rtl/rvfi_commit_serializer.sv
// Buffers up to two retired records per cycle and replays them one per cycle
// on the RVFI side with a running order number, sticky halt and error flags.
module rvfi_commit_serializer #(
   parameter int DEPTH = 8,
   parameter int REC_W = 206
) (
   input  logic clk,
   input  logic rst,
   rvfi_commit_serializer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   // inst sits below pc_rdata and pc_wdata, so it is bits [REC_W-65 : REC_W-96].
   localparam int INST_LSB = REC_W - 96;
   localparam logic [31:0] HALT_INST = 32'h0000_0063;

   logic [REC_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic [63:0]      order_cnt;

   logic             ready;
   logic             push_req;
   logic             push_ok;
   logic             pop;
   logic [AW:0]      n_push;
   logic [REC_W-1:0] head;

   // Two free slots are required even for a single push, so ready depends on count alone.
   assign ready            = (count < (AW+1)'(DEPTH - 1));
   assign bus.commit_ready = ready;

   always_comb begin
      push_req = |bus.commit_valid;
      push_ok  = push_req && ready;
      pop      = (count != '0);
      head     = mem[rd_ptr];
      n_push   = '0;
      if (push_ok) begin
         n_push = (bus.commit_valid == 2'b11) ? (AW+1)'(2) : (AW+1)'(1);
      end
   end

   // NOTE: the storage array has no reset; pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         if (bus.commit_valid == 2'b10) mem[wr_ptr] <= bus.commit_rec1;
         else                           mem[wr_ptr] <= bus.commit_rec0;
         if (bus.commit_valid == 2'b11) mem[wr_ptr + AW'(1)] <= bus.commit_rec1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         count            <= '0;
         order_cnt        <= '0;
         bus.rvfi_commit  <= 1'b0;
         bus.rvfi_rec     <= '0;
         bus.rvfi_order   <= '0;
         bus.halt         <= 1'b0;
         bus.overflow_err <= 1'b0;
         bus.protocol_err <= 1'b0;
      end else begin
         wr_ptr          <= wr_ptr + n_push[AW-1:0];
         count           <= count + n_push - (AW+1)'(pop);
         bus.rvfi_commit <= pop;
         if (pop) begin
            rd_ptr         <= rd_ptr + AW'(1);
            bus.rvfi_rec   <= head;
            bus.rvfi_order <= order_cnt;
            order_cnt      <= order_cnt + 64'd1;
            if (head[INST_LSB +: 32] == HALT_INST) bus.halt <= 1'b1;
         end
         if (push_req && !ready)           bus.overflow_err <= 1'b1;
         if (bus.commit_valid == 2'b10)    bus.protocol_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// Directed and random stimulus for rvfi_commit_serializer, checked every cycle
// against a queue-based model of the retire stream.
module tb_rvfi_commit_serializer;
   localparam int DEPTH = 8;
   localparam int REC_W = 206;
   localparam int INST_LSB = REC_W - 96;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rvfi_commit_serializer_if #(.REC_W(REC_W)) bus ();
   rvfi_commit_serializer #(.DEPTH(DEPTH), .REC_W(REC_W)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Model: the buffered stream is simply a queue of records in program order.
   logic [REC_W-1:0] q [$];
   logic [REC_W-1:0] m_rec;
   logic [63:0]      m_order_next;
   logic [63:0]      m_order;
   logic             m_commit, m_halt, m_ovf, m_prot;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [REC_W-1:0] mk_rec(input logic [31:0] pc, input logic [31:0] inst);
      return {pc, pc + 32'd4, inst, 1'b1, 5'($urandom), $urandom, $urandom,
              4'($urandom), 4'($urandom), $urandom};
   endfunction

   task automatic model_reset();
      q.delete();
      m_rec = '0; m_order = '0; m_order_next = '0;
      m_commit = 0; m_halt = 0; m_ovf = 0; m_prot = 0;
   endtask

   task automatic check_outputs(input string ctx);
      check({ctx, ".commit"}, bus.rvfi_commit, m_commit);
      check({ctx, ".rec"},    bus.rvfi_rec,    m_rec);
      check({ctx, ".order"},  bus.rvfi_order,  m_order);
      check({ctx, ".halt"},   bus.halt,        m_halt);
      check({ctx, ".ovf"},    bus.overflow_err, m_ovf);
      check({ctx, ".prot"},   bus.protocol_err, m_prot);
   endtask

   // One clock: inputs are already driven; predict, clock, compare.
   task automatic step(input string ctx);
      bit ready;
      ready = (q.size() <= DEPTH - 2);
      check({ctx, ".ready"}, bus.commit_ready, ready);
      if (q.size() != 0) begin
         m_commit = 1;
         m_rec    = q.pop_front();
         m_order  = m_order_next;
         m_order_next++;
         if (m_rec[INST_LSB +: 32] == 32'h63) m_halt = 1;
      end else begin
         m_commit = 0;
      end
      if (bus.commit_valid == 2'b10) m_prot = 1;
      if (bus.commit_valid != 2'b00) begin
         if (!ready) m_ovf = 1;
         else begin
            if (bus.commit_valid == 2'b10) q.push_back(bus.commit_rec1);
            else                           q.push_back(bus.commit_rec0);
            if (bus.commit_valid == 2'b11) q.push_back(bus.commit_rec1);
         end
      end
      @(posedge clk); #1;
      check_outputs(ctx);
   endtask

   task automatic drive(input logic [1:0] v, input logic [REC_W-1:0] r0, input logic [REC_W-1:0] r1);
      bus.commit_valid = v;
      bus.commit_rec0  = r0;
      bus.commit_rec1  = r1;
   endtask

   task automatic idle(input int n, input string ctx);
      drive(2'b00, '0, '0);
      for (int i = 0; i < n; i++) step(ctx);
   endtask

   initial begin
      logic [31:0] pc;
      logic [31:0] ins;
      model_reset();
      drive(2'b00, '0, '0);
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");
      check("reset.ready", bus.commit_ready, 1'b1);
      rst = 1'b0;

      // Single push, latency of one edge, then idle.
      drive(2'b01, mk_rec(32'h6000_0000, 32'h13), '0);
      step("single.push");
      drive(2'b00, '0, '0);
      step("single.out");
      check("single.order0", bus.rvfi_order, 64'd0);
      step("single.empty");

      // Dual pushes in program order until ready drops at count 7.
      pc = 32'h6000_0004;
      for (int i = 0; i < 6; i++) begin
         drive(2'b11, mk_rec(pc, 32'h13), mk_rec(pc + 32'd4, 32'h13));
         pc += 32'd8;
         step("dual");
      end
      check("dual.ready_low", bus.commit_ready, 1'b0);
      check("dual.no_ovf", bus.overflow_err, 1'b0);

      // This pair is dropped because ready is low.
      drive(2'b11, mk_rec(32'hDEAD_0000, 32'h13), mk_rec(32'hDEAD_0004, 32'h13));
      step("ovf.push");
      check("ovf.set", bus.overflow_err, 1'b1);
      idle(10, "ovf.drain");
      check("ovf.sticky", bus.overflow_err, 1'b1);

      // Illegal lane pattern: rec1 pushed alone.
      drive(2'b10, mk_rec(32'h6000_000C, 32'h13), mk_rec(32'h6000_0010, 32'h13));
      step("prot.push");
      check("prot.set", bus.protocol_err, 1'b1);
      idle(3, "prot.drain");

      // Random traffic; the halt opcode is kept out so halt stays low here.
      for (int i = 0; i < 150; i++) begin
         ins = $urandom;
         if (ins == 32'h63) ins = 32'h13;
         drive(2'($urandom_range(0, 3)), mk_rec($urandom, ins), mk_rec($urandom, $urandom | 32'h100));
         if ($urandom_range(0, 3) == 0) bus.commit_valid = 2'b00;
         step("rand");
      end
      idle(10, "rand.drain");
      check("rand.no_halt", bus.halt, 1'b0);

      // Halt on lane 1, then two more records drain with halt held.
      drive(2'b11, mk_rec(32'h6000_0100, 32'h13), mk_rec(32'h6000_0104, 32'h63));
      step("halt.push");
      drive(2'b11, mk_rec(32'h6000_0108, 32'h13), mk_rec(32'h6000_010C, 32'h13));
      step("halt.push2");
      drive(2'b00, '0, '0);
      step("halt.rec1");
      check("halt.rise", bus.halt, 1'b1);
      idle(4, "halt.drain");
      check("halt.sticky", bus.halt, 1'b1);

      // Build up 5 entries, then assert reset between clock edges.
      for (int i = 0; i < 4; i++) begin
         drive(2'b11, mk_rec(32'h7000_0000 + 32'(i * 8), 32'h13), mk_rec(32'h7000_0004 + 32'(i * 8), 32'h13));
         step("mid.fill");
      end
      check("mid.five", 32'(q.size()), 32'd5);
      drive(2'b00, '0, '0);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_outputs("mid.reset");
      check("mid.ready", bus.commit_ready, 1'b1);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      drive(2'b01, mk_rec(32'h8000_0000, 32'h13), '0);
      step("post.push");
      drive(2'b00, '0, '0);
      step("post.out");
      check("post.commit", bus.rvfi_commit, 1'b1);
      check("post.order0", bus.rvfi_order, 64'd0);
      idle(2, "post.idle");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
